adc_spi_capture: RTL and testbench
==================================

// Module: adc_spi_capture
// PURPOSE
//  Upstream stage of the compare/counter PWM block: reads a 12-bit serial ADC
//  (AD7476-style frame: 4 leading zeros, then 12 data bits MSB first) at a fixed rate.
//  Presents the top 10 bits as the held duty word d[9:0] consumed by compycont.
//  d stays stable between updates, so the PWM comparator never sees a partial word.
// PARAMETERS
//  CLK_DIV        4     clk cycles per sclk half-period (>=2)
//  SAMPLE_PERIOD  2000  clk cycles between frame starts; must be >= 2*CLK_DIV*FRAME_BITS+2*CLK_DIV+4
//  FRAME_BITS     16    sclk cycles per frame (4 lead zeros + 12 data)
// PORTS
//  clk      in   1   system clock, all logic on rising edge
//  reset    in   1   asynchronous, active-high reset
//  en       in   1   1 = start frames on period ticks; 0 = no new frames (current one completes)
//  miso     in   1   ADC serial data, changes after sclk falling edge
//  sclk     out  1   ADC serial clock, idles high, registered
//  cs_n     out  1   ADC chip select, active low, registered
//  d        out  10  last captured sample[11:2]; to compycont.d
//  d_valid  out  1   one-cycle pulse when d updates
//  busy     out  1   high while cs_n is low
// BEHAVIOUR
//  Reset (async): sclk=1, cs_n=1, d=0, d_valid=0, busy=0, period counter=0, FSM=IDLE, shift reg=0.
//  Period counter: free-running 0..SAMPLE_PERIOD-1, wraps to 0; tick = (count==0).
//   It runs regardless of en and of FSM state.
//  FSM: IDLE -> SETUP -> SHIFT_LO <-> SHIFT_HI -> DONE -> IDLE.
//   IDLE: on tick && en, next edge cs_n=0, busy=1, go SETUP.
//    A tick while not IDLE is dropped; the parameter constraint makes this impossible.
//   SETUP: hold sclk=1 for CLK_DIV cycles, then sclk=0, go SHIFT_LO.
//   SHIFT_LO: CLK_DIV cycles, then sclk=1 and sample miso into shift reg LSB (shift left), go SHIFT_HI.
//   SHIFT_HI: CLK_DIV cycles, then bit counter+1.
//    If count < FRAME_BITS: sclk=0, go SHIFT_LO.
//    If count == FRAME_BITS: go DONE.
//   DONE (one cycle): cs_n=1, busy=0, d=shift[11:2], d_valid=1, go IDLE.
//  Timing at defaults: cs_n low for CLK_DIV + 2*CLK_DIV*FRAME_BITS = 132 cycles.
//   d/d_valid update on the same edge where cs_n rises.
//  Exactly FRAME_BITS bits are sampled per frame. Bits 15..12 (lead zeros) are discarded even if nonzero.
//   Bits 1..0 are truncated, not rounded.
//  en deasserted mid-frame: the frame completes and d updates; no further frames start.
//  Reset mid-frame: the frame is aborted; cs_n and sclk return high immediately; d clears to 0; no d_valid.
//  d changes only in DONE; d_valid is never high for two consecutive cycles.
// STRUCTURE
//  Include file adc_spi_defs.vh holds:
//   - FSM state localparams (3-bit: IDLE, SETUP, SHIFT_LO, SHIFT_HI, DONE)
//   - LEAD_ZEROS=4, ADC_BITS=12, D_BITS=10
//  Sub-module tick_gen (#(PERIOD)): clk, reset -> tick. The rest stays flat: FSM, sclk divider
//   counter, bit counter, 16-bit shift reg, d register.
// TESTING (tb: CLK_DIV=4, SAMPLE_PERIOD=400, behavioural ADC model driving miso on sclk falling edge)
//  1. reset 100ns, en=1, ADC value 12'hB54 -> cs_n low 132 cycles, 16 sclk rising edges,
//     d=10'd725, single d_valid pulse as cs_n rises.
//  2. ADC value changes to 12'h190 -> next frame gives d=10'd100. d holds 725 until that DONE edge.
//  3. ADC 12'hFFF with lead bits driven 1 -> d=10'd1023 (lead bits ignored).
//     ADC 12'h003 -> d=10'd0.
//  4. en=0 asserted 40 cycles into a frame -> that frame completes with d updated.
//     cs_n then stays high for >=3 periods; en=1 restarts on the next tick.
//  5. reset pulsed at cycle 60 of a frame -> cs_n=1, sclk=1, d=0 asynchronously, no d_valid.
//     Next frame is clean, with a correct d.
//  6. Checker on every frame: exactly 16 sclk rising edges while cs_n=0.
//     sclk=1 whenever cs_n=1. Frame starts spaced by exactly 400 cycles.

Source files
------------

// File: rtl/adc_spi_capture_pkg.sv
// Shared FSM encoding and frame geometry for the serial ADC capture path.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package adc_spi_capture_pkg;

   localparam int LEAD_ZEROS = 4;
   localparam int ADC_BITS   = 12;
   localparam int D_BITS     = 10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/adc_spi_capture_tick_gen.sv
// Frame-rate tick: free-running 0..PERIOD-1 counter, tick while the count is zero.
// Latency: tick is high in the first cycle after reset, then once every PERIOD cycles.
// Backpressure: none; the counter never stalls.
module adc_spi_capture_tick_gen #(
   parameter int PERIOD = 2000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] count;

   // Wrapping period counter, independent of the capture FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (count == CW'(PERIOD - 1)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == '0);

endmodule

// File: rtl/adc_spi_capture.sv
// Reads one AD7476-style frame per period tick and holds sample[11:2] as duty word d.
// Latency: cs_n low CLK_DIV + 2*CLK_DIV*FRAME_BITS cycles; d/d_valid update as cs_n rises.
// Backpressure: none; d_valid is a one-cycle pulse, a tick arriving mid-frame is dropped.
module adc_spi_capture
   import adc_spi_capture_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 2000,
   parameter int FRAME_BITS    = LEAD_ZEROS + ADC_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              miso,
   output logic              sclk,
   output logic              cs_n,
   output logic [D_BITS-1:0] d,
   output logic              d_valid,
   output logic              busy
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(FRAME_BITS + 1);

   state_t                  state, state_nxt;
   logic [DIV_W-1:0]        div, div_nxt;
   logic [BIT_W-1:0]        bits, bits_nxt;
   logic [FRAME_BITS-1:0]   shift, shift_nxt;
   logic                    sclk_nxt, cs_n_nxt, busy_nxt, d_valid_nxt;
   logic [D_BITS-1:0]       d_nxt;
   logic                    tick;
   logic                    div_end;

   adc_spi_capture_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Last cycle of an sclk half-period (or of the cs_n-to-first-edge setup).
   assign div_end = (div == DIV_W'(CLK_DIV - 1));

   // State and registered-output update; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         div     <= '0;
         bits    <= '0;
         shift   <= '0;
         sclk    <= 1'b1;
         cs_n    <= 1'b1;
         busy    <= 1'b0;
         d       <= '0;
         d_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         div     <= div_nxt;
         bits    <= bits_nxt;
         shift   <= shift_nxt;
         sclk    <= sclk_nxt;
         cs_n    <= cs_n_nxt;
         busy    <= busy_nxt;
         d       <= d_nxt;
         d_valid <= d_valid_nxt;
      end
   end

   // Next-state and next-output logic. The frame-end outputs (cs_n high, d load,
   // d_valid) are set on the edge that enters DONE so they appear together.
   always_comb begin
      state_nxt   = state;
      div_nxt     = div;
      bits_nxt    = bits;
      shift_nxt   = shift;
      sclk_nxt    = sclk;
      cs_n_nxt    = cs_n;
      busy_nxt    = busy;
      d_nxt       = d;
      d_valid_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (tick && en) begin
               cs_n_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               div_nxt   = '0;
               bits_nxt  = '0;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (div_end) begin
               sclk_nxt  = 1'b0;
               div_nxt   = '0;
               state_nxt = SHIFT_LO;
            end else begin
               div_nxt = div + 1'b1;
            end
         end
         SHIFT_LO: begin
            if (div_end) begin
               sclk_nxt  = 1'b1;
               shift_nxt = (shift << 1) | FRAME_BITS'(miso);
               div_nxt   = '0;
               state_nxt = SHIFT_HI;
            end else begin
               div_nxt = div + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (div_end) begin
               div_nxt  = '0;
               bits_nxt = bits + 1'b1;
               if (bits + 1'b1 == BIT_W'(FRAME_BITS)) begin
                  cs_n_nxt    = 1'b1;
                  busy_nxt    = 1'b0;
                  d_nxt       = shift[ADC_BITS-1 -: D_BITS];
                  d_valid_nxt = 1'b1;
                  state_nxt   = DONE;
               end else begin
                  sclk_nxt  = 1'b0;
                  state_nxt = SHIFT_LO;
               end
            end else begin
               div_nxt = div + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: behavioural ADC on miso, scoreboard of expected duty words.
// Latency: expected word queued at cs_n fall, popped when d_valid is seen.
// Backpressure: none; the monitor samples every falling clk edge.
module tb_adc_spi_capture;

   localparam int CLK_DIV = 4;
   localparam int PERIOD  = 400;
   localparam int LOW_CYC = CLK_DIV + 2 * CLK_DIV * 16;

   logic       clk;
   logic       reset;
   logic       en;
   logic       miso;
   logic       sclk;
   logic       cs_n;
   logic [9:0] d;
   logic       d_valid;
   logic       busy;

   // ADC-side stimulus state
   logic [11:0] val;
   logic [3:0]  lead;
   logic [15:0] word;

   logic [9:0] sb[$];
   int tests = 0;
   int fails = 0;

   // monitor state
   int  cyc = 0;
   int  last_start = 0;
   bit  have_start = 0;
   bit  gap_ok = 0;
   int  low_cyc = 0;
   int  rises = 0;
   int  dv_cnt = 0;
   logic prev_cs = 1'b1;
   logic prev_sclk = 1'b1;
   logic prev_dv = 1'b0;
   logic [9:0] held = '0;

   adc_spi_capture #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (PERIOD),
      .FRAME_BITS    (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .miso    (miso),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .d       (d),
      .d_valid (d_valid),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ADC frame start: latch the 16-bit frame and queue the duty word it should yield.
   initial begin
      forever begin
         @(negedge cs_n);
         word = {lead, val};
         sb.push_back(10'(val / 12'd4));
      end
   end

   // ADC shifts the next bit out MSB first after each sclk falling edge.
   initial begin
      miso = 1'b0;
      forever begin
         @(negedge sclk);
         if (!cs_n) begin
            miso = word[15];
            word = word << 1;
         end
      end
   end

   // Monitor: frame shape, idle levels, d hold, d_valid pulse and scoreboard compare.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_cs    = 1'b1;
            prev_sclk  = 1'b1;
            prev_dv    = 1'b0;
            low_cyc    = 0;
            rises      = 0;
            held       = '0;
            have_start = 0;
         end else begin
            cyc++;
            if (cs_n) chk("sclk_idle_high", int'(sclk), 1);
            chk("busy_eq_cs", int'(busy), int'(!cs_n));
            if (!cs_n && prev_cs) begin
               if (have_start) begin
                  chk("start_spacing_mult", (cyc - last_start) % PERIOD, 0);
                  if (!gap_ok) chk("start_spacing", cyc - last_start, PERIOD);
               end
               last_start = cyc;
               have_start = 1;
               low_cyc    = 0;
               rises      = 0;
            end
            if (!cs_n) begin
               low_cyc++;
               if (sclk && !prev_sclk) rises++;
            end
            if (cs_n && !prev_cs) begin
               chk("cs_low_cycles", low_cyc, LOW_CYC);
               chk("sclk_rises", rises, 16);
               chk("dvalid_at_cs_rise", int'(d_valid), 1);
            end
            if (d_valid) begin
               dv_cnt++;
               chk("dvalid_single", int'(prev_dv), 0);
               chk("dvalid_cs_edge", int'(cs_n && !prev_cs), 1);
               if (sb.size() == 0) begin
                  chk("sb_nonempty", 0, 1);
               end else begin
                  held = sb.pop_front();
                  chk("d_scoreboard", int'(d), int'(held));
               end
            end else begin
               chk("d_hold", int'(d), int'(held));
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
            prev_dv   = d_valid;
         end
      end
   end

   task automatic wait_dv(input int maxc, input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!d_valid && n < maxc);
      if (!d_valid) chk(nm, 0, 1);
   endtask

   task automatic wait_cs_low(input int maxc, input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cs_n && n < maxc);
      if (cs_n) chk(nm, 0, 1);
   endtask

   initial begin
      bit stray;
      logic [11:0] v;
      reset = 1'b1;
      en    = 1'b0;
      lead  = 4'h0;
      val   = 12'hB54;
      word  = '0;
      #3;
      chk("rst_sclk", int'(sclk), 1);
      chk("rst_cs_n", int'(cs_n), 1);
      chk("rst_d", int'(d), 0);
      chk("rst_dvalid", int'(d_valid), 0);
      chk("rst_busy", int'(busy), 0);
      #97;
      reset = 1'b0;
      en    = 1'b1;

      // basic frames with fixed values
      wait_dv(600, "t1_timeout");
      chk("t1_d_725", int'(d), 725);
      val = 12'h190;
      wait_dv(600, "t2_timeout");
      chk("t2_d_100", int'(d), 100);
      lead = 4'hF;
      val  = 12'hFFF;
      wait_dv(600, "t3a_timeout");
      chk("t3_d_1023", int'(d), 1023);
      lead = 4'($urandom);
      val  = 12'h003;
      wait_dv(600, "t3b_timeout");
      chk("t3_d_0", int'(d), 0);
      lead = 4'h0;

      // en dropped mid-frame: frame completes, then no frames until en returns
      v   = 12'($urandom);
      val = v;
      wait_cs_low(600, "t4_start_timeout");
      repeat (40) @(posedge clk);
      #1;
      en     = 1'b0;
      gap_ok = 1;
      wait_dv(200, "t4_timeout");
      chk("t4_d", int'(d), int'(v / 12'd4));
      stray = 0;
      repeat (3 * PERIOD) begin
         @(negedge clk);
         if (!cs_n) stray = 1;
      end
      chk("t4_no_frames", int'(stray), 0);
      v   = 12'($urandom);
      val = v;
      en  = 1'b1;
      wait_cs_low(PERIOD + 1, "t4_restart_timeout");
      wait_dv(200, "t4_restart_dv_timeout");
      chk("t4_restart_d", int'(d), int'(v / 12'd4));
      gap_ok = 0;

      // reset mid-frame: abort, then a clean frame
      val = 12'($urandom);
      wait_cs_low(600, "t5_start_timeout");
      repeat (60) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_cs_n", int'(cs_n), 1);
      chk("t5_sclk", int'(sclk), 1);
      chk("t5_d", int'(d), 0);
      chk("t5_dvalid", int'(d_valid), 0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("t5_dvalid_hold", int'(d_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      v   = 12'($urandom);
      val = v;
      wait_dv(600, "t5_timeout");
      chk("t5_clean_d", int'(d), int'(v / 12'd4));

      // random frames with random lead bits
      for (int i = 0; i < 8; i++) begin
         lead = 4'($urandom);
         v    = 12'($urandom);
         val  = v;
         wait_dv(600, "rnd_timeout");
         chk("rnd_d", int'(d), int'(v / 12'd4));
      end

      repeat (10) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("dvalid_count", dv_cnt, 15);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
